// File: rtl/nth_root_seq.sv
`default_nettype none
// ============================================================================
// Module   : nth_root_seq
// Purpose  : Sequential n-th root, Q(IN_W).(FRAC_W) result, MSB-first search.
// Revision : 1.0
// ============================================================================
module nth_root_seq #(
    parameter  int IN_W   = 10,
    parameter  int FRAC_W = 10,
    parameter  int EXP_W  = 3,
    localparam int RES_W  = IN_W + FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_radicand,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_root,
    output logic              out_exact,
    output logic              out_err
);

    localparam int PROD_W = 2 * RES_W;
    localparam int BIT_W  = $clog2(RES_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAND = 2'd1,
        S_POW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [IN_W-1:0]    x_q;
    logic [EXP_W-1:0]   n_q;
    logic [PROD_W-1:0]  xe_q;
    logic [RES_W-1:0]   root_q;
    logic [RES_W-1:0]   cand_q;
    logic [RES_W-1:0]   acc_q;
    logic [EXP_W-1:0]   cnt_q;
    logic [BIT_W-1:0]   bit_q;
    logic               exact_q;
    logic               err_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [RES_W-1:0]   out_root_q;
    logic               out_exact_q;
    logic               out_err_q;

    logic [RES_W-1:0]   cand_d;
    logic [PROD_W-1:0]  w_prod;
    logic [EXP_W:0]     w_cnt_inc;
    logic               w_fits;
    logic               w_last_mul;

    assign cand_d     = root_q | (RES_W'(1) << bit_q);
    assign w_prod     = {{RES_W{1'b0}}, acc_q} * {{RES_W{1'b0}}, cand_q};
    assign w_cnt_inc  = {1'b0, cnt_q} + 1'b1;
    assign w_fits     = (w_prod <= xe_q);
    assign w_last_mul = (w_cnt_inc == {1'b0, n_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            n_q         <= '0;
            xe_q        <= '0;
            root_q      <= '0;
            cand_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            exact_q     <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
            out_exact_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q        <= in_radicand;
                        n_q        <= in_exp;
                        xe_q       <= PROD_W'(in_radicand) << (2 * FRAC_W);
                        root_q     <= '0;
                        bit_q      <= BIT_W'(RES_W - 1);
                        exact_q    <= 1'b0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CAND;
                    end
                end
                S_CAND: begin
                    if (n_q == '0) begin
                        err_q   <= 1'b1;
                        root_q  <= '0;
                        state_q <= S_DONE;
                    end else if (n_q == EXP_W'(1)) begin
                        root_q  <= RES_W'(x_q) << FRAC_W;
                        exact_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (x_q == '0) begin
                        root_q  <= '0;
                        exact_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cand_q  <= cand_d;
                        acc_q   <= cand_d;
                        cnt_q   <= EXP_W'(1);
                        state_q <= S_POW;
                    end
                end
                S_POW: begin
                    // Full-width product is compared before any truncation
                    if (w_fits && w_last_mul)
                        root_q <= cand_q;
                    if (w_fits && !w_last_mul) begin
                        acc_q <= w_prod[FRAC_W +: RES_W];
                        cnt_q <= cnt_q + 1'b1;
                    end else if (w_prod == xe_q) begin
                        exact_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (bit_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        bit_q   <= bit_q - 1'b1;
                        state_q <= S_CAND;
                    end
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_root_q  <= root_q;
                        out_exact_q <= exact_q;
                        out_err_q   <= err_q;
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
    assign out_exact = out_exact_q;
    assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_nth_root_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nth_root_seq
// Purpose  : Scoreboard bench for nth_root_seq against a truncation-chain model.
// Revision : 1.0
// ============================================================================
module tb_nth_root_seq;

    localparam int IN_W   = 10;
    localparam int FRAC_W = 10;
    localparam int EXP_W  = 3;
    localparam int RES_W  = IN_W + FRAC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_radicand;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_root;
    logic              out_exact;
    logic              out_err;

    nth_root_seq #(.IN_W(IN_W), .FRAC_W(FRAC_W), .EXP_W(EXP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_radicand (in_radicand),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_root    (out_root),
        .out_exact   (out_exact),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RES_W-1:0] root;
        logic             exact;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: same MSB-first search and truncation chain, written as plain loops
    function automatic exp_t model(input int x, input int n);
        exp_t        e;
        logic [39:0] xe, acc, p;
        logic [19:0] c;
        bit          stop;
        e.root = '0; e.exact = 1'b0; e.err = 1'b0; stop = 1'b0;
        xe = 40'(x) << 20;
        if (n == 0) e.err = 1'b1;
        else if (n == 1) begin e.root = 20'(x) << 10; e.exact = 1'b1; end
        else if (x == 0) e.exact = 1'b1;
        else begin
            for (int b = 19; b >= 0 && !stop; b--) begin
                c   = e.root | (20'd1 << b);
                acc = 40'(c);
                for (int k = 1; k < n; k++) begin
                    p = acc * 40'(c);
                    if (p > xe) break;
                    if (k == n - 1) begin
                        e.root = c;
                        if (p == xe) begin e.exact = 1'b1; stop = 1'b1; end
                    end else acc = p >> 10;
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output: observed root=%0h expected no output", out_root);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("root",  40'(out_root),  40'(e.root));
                chk("exact", 40'(out_exact), 40'(e.exact));
                chk("err",   40'(out_err),   40'(e.err));
            end
        end
    end

    task automatic send(input int x, input int n);
        bit taken;
        taken = 1'b0;
        @(posedge clk); #1;
        in_radicand = IN_W'(x);
        in_exp      = EXP_W'(n);
        in_valid    = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin taken = 1'b1; break; end
        end
        if (!taken) begin
            checks++; errors++;
            $error("FAIL accept_timeout: observed in_ready=0 expected 1");
        end else sb.push_back(model(x, n));
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = cyc - acc_cyc; break; end
        end
        if (lat < 0) begin
            checks++; errors++;
            $error("FAIL out_timeout: observed out_valid=0 expected 1");
        end
    endtask

    task automatic run(input int x, input int n);
        int lat;
        bit ok;
        send(x, n);
        wait_out(lat);
        if (lat >= 0) begin
            ok = (n < 2 || x == 0) ? (lat == 2) : (lat <= RES_W * n + 1);
            chk("latency", {39'd0, ok}, 40'd1);
            @(negedge clk);
            chk("valid_pulse", 40'(out_valid), 40'd0);
            chk("ready_back",  40'(in_ready),  40'd1);
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; in_radicand = '0; in_exp = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  40'(in_ready),  40'd1);
        chk("rst_out_valid", 40'(out_valid), 40'd0);
        chk("rst_out_root",  40'(out_root),  40'd0);
        chk("rst_out_exact", 40'(out_exact), 40'd0);
        chk("rst_out_err",   40'(out_err),   40'd0);

        // Directed cases with hand-derived values
        run(8, 3);
        chk("cube8", 40'(out_root), 40'h00800);
        run(2, 2);
        chk("sqrt2", 40'(out_root), 40'h005A8);
        run(1000, 1);
        chk("n1", 40'(out_root), 40'hFA000);
        run(0, 5);
        run(300, 0);
        chk("n0_err", 40'(out_err), 40'd1);

        // Backpressure with a competing request held by the producer
        out_ready = 1'b0;
        send(27, 3);
        wait_out(lat);
        @(posedge clk); #1;
        in_radicand = 10'd16; in_exp = 3'd2; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_valid", 40'(out_valid), 40'd1);
            chk("bp_root",  40'(out_root),  40'h00C00);
            chk("bp_exact", 40'(out_exact), 40'd1);
            chk("bp_busy",  40'(in_ready),  40'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_busy", 40'(in_ready), 40'd0);
        send(16, 2);
        wait_out(lat);
        chk("after_bp_root", 40'(out_root), 40'h01000);

        // Reset during a long computation drops the request
        @(negedge clk);
        send(1023, 7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_in_ready",  40'(in_ready),  40'd1);
        chk("midrst_out_valid", 40'(out_valid), 40'd0);
        chk("midrst_out_root",  40'(out_root),  40'd0);
        run(16, 4);
        chk("root4_16", 40'(out_root), 40'h00800);

        // Boundary and random sweep against the model
        run(1023, 7);
        run(1023, 2);
        run(1, 7);
        for (int i = 0; i < 40; i++)
            run(int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)));

        repeat (4) @(negedge clk);
        chk("sb_drained", 40'(sb.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nth_root_seq.md
Name: nth_root_seq

Overview:
- Parametrised sequential fixed-point n-th root engine: out_root = floor-search of x^(1/n) for unsigned integer radicand x and integer exponent n.
- Bit-serial successive approximation, MSB first; each candidate is raised to the n-th power by repeated multiply, with an early abort on overshoot.
- Adds valid/ready handshakes on both sides, output hold under backpressure, an exact-match flag and an error flag for n=0.
- Sits as a shared arithmetic unit behind the command decoder, next to the divider.

Parameters:
- IN_W, 10, integer radicand width.
- FRAC_W, 10, fractional bits of result (result format Q IN_W.FRAC_W).
- EXP_W, 3, exponent width; legal n = 1..2^EXP_W-1.
- RES_W, IN_W+FRAC_W (derived, localparam), result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- in_radicand  in  IN_W  unsigned integer x.
- in_exp  in  EXP_W  unsigned exponent n.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_root  out  RES_W  result, Q IN_W.FRAC_W, unsigned.
- out_exact  out  1  result^n (truncated chain) equals x exactly.
- out_err  out  1  n was 0; out_root=0.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, in_ready=1, out_valid=0, out_root=0, out_exact=0, out_err=0. Reset has priority over every other event, mid-operation included; the in-flight request is dropped and no output is produced.
- States: IDLE, CAND, POW, DONE. All outputs are registered.
- IDLE: in_ready=1. On in_valid&in_ready, capture x, n and xe = x<<(2*FRAC_W) (2*RES_W bits). Set root=0, bit=RES_W-1, go to CAND. Inputs are ignored outside IDLE.
- CAND, shortcut cases, which all go to DONE:
  - n=0: out_err=1, root=0.
  - n=1: root = x<<FRAC_W, exact=1.
  - x=0: root=0, exact=1.
- CAND, otherwise: cand = root | (1<<bit), acc=cand, cnt=1, go to POW.
- POW, one multiply per cycle: p = acc*cand (2*RES_W bits, no truncation before compare).
  - If p > xe: reject bit.
  - Else if cnt+1==n: accept bit (root=cand). If p==xe, set exact=1 and go to DONE.
  - Else: acc = p>>FRAC_W, cnt=cnt+1, stay in POW.
- After a reject or non-exact accept: if bit==0 go to DONE, else bit=bit-1 and go to CAND.
- Width rule: an accepted partial product satisfies p<=xe, so acc<=x<<FRAC_W always fits RES_W bits. acc truncates toward zero at every step.
- DONE: out_valid=1, and out_root/out_exact/out_err are stable. They must not change while out_valid=1 and out_ready=0. On out_valid&out_ready, go to IDLE: out_valid=0 and in_ready=1 the next cycle, and out_root keeps its last value.
- Latency from the accepting edge to out_valid high:
  - shortcut cases: exactly 2 cycles;
  - normal case: at most RES_W*n+1 cycles (n cycles per bit), fewer on overshoot abort or exact match.
- Throughput: one request in flight. in_ready is low from the cycle after acceptance until the cycle after the output handshake.
- out_ready may be high before out_valid; that is harmless. A request presented while busy is held by the producer (standard valid/ready).

Test Plan:
- x=8, n=3, out_ready=1 -> out_root=0x00800 (2.0), out_exact=1, out_err=0; out_valid pulses for exactly 1 cycle.
- x=2, n=2 -> out_root=0x005A8 (1448/1024), out_exact=0. Bit 0 candidate 1449 is rejected (1449^2=2099601 > 2097152).
- x=1000, n=1 -> out_root=0xFA000, out_exact=1, out_valid exactly 2 cycles after acceptance. x=0, n=5 -> out_root=0, out_exact=1, latency 2. n=0 -> out_err=1, out_root=0.
- Backpressure: x=27, n=3 with out_ready=0 for 6 cycles after out_valid rises -> out_root=0x00C00 (3.0) and out_exact=1 held stable. in_ready stays 0 and a new in_valid is not accepted until 1 cycle after out_ready rises.
- Reset mid-run: x=1023, n=7, assert rst 10 cycles after acceptance -> the next cycle shows in_ready=1 and out_valid=0. A following x=16, n=4 request -> 0x00800, exact=1.
- Random sweep over x=0..1023, n=0..7 versus a bit-accurate model (same truncation chain): results match exactly, and latency never exceeds RES_W*n+1.
